// File: rtl/cursor_motion_mapper_if.sv
// Frame, calibration and cursor-output signals of the cursor motion mapper.
// The master side drives features/calibration; the slave side is the mapper.
interface cursor_motion_mapper_if #(
    parameter int DATA_W = 16
);
    logic                     valid;
    logic signed [DATA_W-1:0] feat_x;
    logic signed [DATA_W-1:0] feat_y;
    logic signed [DATA_W-1:0] offset_x;
    logic signed [DATA_W-1:0] offset_y;
    logic                     calibrated;
    logic                     recenter;
    logic [11:0]              cursor_x;
    logic [11:0]              cursor_y;
    logic signed [7:0]        dx;
    logic signed [7:0]        dy;
    logic                     out_valid;
    logic                     active;

    modport master (
        output valid, feat_x, feat_y, offset_x, offset_y, calibrated, recenter,
        input  cursor_x, cursor_y, dx, dy, out_valid, active
    );

    modport slave (
        input  valid, feat_x, feat_y, offset_x, offset_y, calibrated, recenter,
        output cursor_x, cursor_y, dx, dy, out_valid, active
    );
endinterface

// File: rtl/cursor_motion_mapper.sv
// Maps offset-corrected feature frames to a bounded cursor step and a
// screen-clamped integrated cursor position through a short pipeline.
module cursor_motion_mapper #(
    parameter int DEADZONE   = 16,
    parameter int GAIN_SHIFT = 4,
    parameter int MAX_STEP   = 32,
    parameter int SCREEN_W   = 1920,
    parameter int SCREEN_H   = 1080
) (
    input  logic                   clk,
    input  logic                   rst,
    cursor_motion_mapper_if.slave  bus
);
    localparam int DATA_W = 16;
    localparam int ERR_W  = DATA_W + 1;
    localparam int POS_W  = 14;
    localparam logic [11:0]             CTR_X = 12'(SCREEN_W / 2);
    localparam logic [11:0]             CTR_Y = 12'(SCREEN_H / 2);
    localparam logic signed [POS_W-1:0] MAX_X = POS_W'(SCREEN_W - 1);
    localparam logic signed [POS_W-1:0] MAX_Y = POS_W'(SCREEN_H - 1);

    // Magnitude-domain shift keeps rounding symmetric toward zero.
    function automatic logic signed [7:0] step_of(input logic signed [ERR_W-1:0] err);
        logic [ERR_W-1:0]  mag;
        logic [ERR_W-1:0]  sh;
        logic signed [7:0] s8;
        mag = err[ERR_W-1] ? $unsigned(-err) : $unsigned(err);
        if (mag <= ERR_W'(DEADZONE)) sh = '0;
        else                         sh = (mag - ERR_W'(DEADZONE)) >> GAIN_SHIFT;
        if (sh > ERR_W'(MAX_STEP)) sh = ERR_W'(MAX_STEP);
        s8 = 8'(sh);
        return err[ERR_W-1] ? -s8 : s8;
    endfunction

    function automatic logic [11:0] clamp_pos(input logic signed [POS_W-1:0] v,
                                              input logic signed [POS_W-1:0] hi);
        if (v < 0)  return '0;
        if (v > hi) return 12'(hi);
        return 12'(v);
    endfunction

    logic                     cal_q, cal_d;
    logic                     active_q, active_d;
    logic signed [DATA_W-1:0] shadow_x_q, shadow_x_d, shadow_y_q, shadow_y_d;
    logic                     vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] feat_x_p0_q, feat_x_p0_d, feat_y_p0_q, feat_y_p0_d;
    logic signed [ERR_W-1:0]  err_x_p1_q, err_x_p1_d, err_y_p1_q, err_y_p1_d;
    logic signed [7:0]        step_x_p2_q, step_x_p2_d, step_y_p2_q, step_y_p2_d;
    logic [11:0]              cursor_x_q, cursor_x_d, cursor_y_q, cursor_y_d;
    logic signed [7:0]        dx_q, dx_d, dy_q, dy_d;
    logic signed [POS_W-1:0]  sum_x, sum_y;
    logic                     cal_rise, cal_fall;

    always_comb begin
        cal_rise    = bus.calibrated & ~cal_q;
        cal_fall    = ~bus.calibrated & cal_q;
        cal_d       = bus.calibrated;
        active_d    = active_q;
        shadow_x_d  = shadow_x_q;
        shadow_y_d  = shadow_y_q;
        if (cal_rise) begin
            active_d   = 1'b1;
            shadow_x_d = bus.offset_x;
            shadow_y_d = bus.offset_y;
        end
        if (cal_fall) active_d = 1'b0;

        // Stage p0: capture accepted frame
        vld_p0_d    = bus.valid & active_q;
        feat_x_p0_d = bus.feat_x;
        feat_y_p0_d = bus.feat_y;

        // Stage p1: offset-corrected error
        vld_p1_d   = vld_p0_q;
        err_x_p1_d = $signed({feat_x_p0_q[DATA_W-1], feat_x_p0_q}) -
                     $signed({shadow_x_q[DATA_W-1], shadow_x_q});
        err_y_p1_d = $signed({feat_y_p0_q[DATA_W-1], feat_y_p0_q}) -
                     $signed({shadow_y_q[DATA_W-1], shadow_y_q});

        // Stage p2: deadzone, gain and saturation
        vld_p2_d    = vld_p1_q;
        step_x_p2_d = step_of(err_x_p1_q);
        step_y_p2_d = step_of(err_y_p1_q);

        // Output stage: integrate and clamp to the screen
        sum_x       = $signed({2'b00, cursor_x_q}) + POS_W'(step_x_p2_q);
        sum_y       = $signed({2'b00, cursor_y_q}) + POS_W'(step_y_p2_q);
        out_valid_d = vld_p2_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        cursor_x_d  = cursor_x_q;
        cursor_y_d  = cursor_y_q;
        if (vld_p2_q) begin
            dx_d       = step_x_p2_q;
            dy_d       = step_y_p2_q;
            cursor_x_d = clamp_pos(sum_x, MAX_X);
            cursor_y_d = clamp_pos(sum_y, MAX_Y);
        end
        // Losing calibration drops every in-flight frame, including one finishing now.
        if (cal_fall) begin
            vld_p0_d    = 1'b0;
            vld_p1_d    = 1'b0;
            vld_p2_d    = 1'b0;
            out_valid_d = 1'b0;
            dx_d        = dx_q;
            dy_d        = dy_q;
            cursor_x_d  = cursor_x_q;
            cursor_y_d  = cursor_y_q;
        end
        if (bus.recenter) begin
            cursor_x_d = CTR_X;
            cursor_y_d = CTR_Y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cal_q       <= 1'b0;
            active_q    <= 1'b0;
            shadow_x_q  <= '0;
            shadow_y_q  <= '0;
            vld_p0_q    <= 1'b0;
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            out_valid_q <= 1'b0;
            cursor_x_q  <= CTR_X;
            cursor_y_q  <= CTR_Y;
            dx_q        <= '0;
            dy_q        <= '0;
        end else begin
            cal_q       <= cal_d;
            active_q    <= active_d;
            shadow_x_q  <= shadow_x_d;
            shadow_y_q  <= shadow_y_d;
            vld_p0_q    <= vld_p0_d;
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            out_valid_q <= out_valid_d;
            cursor_x_q  <= cursor_x_d;
            cursor_y_q  <= cursor_y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
        end
    end

    always_ff @(posedge clk) begin
        feat_x_p0_q <= feat_x_p0_d;
        feat_y_p0_q <= feat_y_p0_d;
        err_x_p1_q  <= err_x_p1_d;
        err_y_p1_q  <= err_y_p1_d;
        step_x_p2_q <= step_x_p2_d;
        step_y_p2_q <= step_y_p2_d;
    end

    assign bus.cursor_x  = cursor_x_q;
    assign bus.cursor_y  = cursor_y_q;
    assign bus.dx        = dx_q;
    assign bus.dy        = dy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.active    = active_q;
endmodule

// File: tb/tb_cursor_motion_mapper.sv
// Scenario bench for cursor_motion_mapper against an arithmetic reference model.
module tb_cursor_motion_mapper;
    localparam int DZ = 16, GS = 4, MS = 32, SW = 1920, SH = 1080;

    logic clk, rst;
    cursor_motion_mapper_if bus ();

    cursor_motion_mapper #(
        .DEADZONE(DZ), .GAIN_SHIFT(GS), .MAX_STEP(MS), .SCREEN_W(SW), .SCREEN_H(SH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cx = SW / 2, exp_cy = SH / 2, exp_dx = 0, exp_dy = 0;
    int sh_x = 0, sh_y = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    function automatic int ref_step(input int err);
        int mag, s;
        mag = (err < 0) ? -err : err;
        s = (mag <= DZ) ? 0 : (mag - DZ) / (1 << GS);
        if (s > MS) s = MS;
        return (err < 0) ? -s : s;
    endfunction

    function automatic int ref_clamp(input int v, input int hi);
        if (v < 0)  return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_frame(input int fx, input int fy);
        exp_dx = ref_step(fx - sh_x);
        exp_dy = ref_step(fy - sh_y);
        exp_cx = ref_clamp(exp_cx + exp_dx, SW - 1);
        exp_cy = ref_clamp(exp_cy + exp_dy, SH - 1);
    endtask

    // Drives one frame and returns how many edges passed until out_valid (bounded at 8).
    task automatic run_frame(input int fx, input int fy, output int ticks);
        bus.feat_x = 16'(fx);
        bus.feat_y = 16'(fy);
        bus.valid  = 1'b1;
        tick();
        ticks = 1;
        bus.valid = 1'b0;
        while (!bus.out_valid && ticks < 8) begin
            tick();
            ticks++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++; if (bus.cursor_x !== 12'd960) begin n_fail++; $display("FAIL reset_cursor_x: got %0d required 960", bus.cursor_x); end
        n_checks++; if (bus.cursor_y !== 12'd540) begin n_fail++; $display("FAIL reset_cursor_y: got %0d required 540", bus.cursor_y); end
        n_checks++; if (bus.dx !== 8'sd0) begin n_fail++; $display("FAIL reset_dx: got %0d required 0", bus.dx); end
        n_checks++; if (bus.dy !== 8'sd0) begin n_fail++; $display("FAIL reset_dy: got %0d required 0", bus.dy); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
        n_checks++; if (bus.active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b required 0", bus.active); end
    endtask

    task automatic test_deadzone_gain();
        int fxs[2] = '{116, 180};
        int lat, pulses;
        bus.offset_x   = 16'sd100;
        bus.offset_y   = -16'sd50;
        bus.calibrated = 1'b1;
        bus.valid      = 1'b1;
        bus.feat_x     = 16'sd32000;
        bus.feat_y     = 16'sd0;
        tick();
        bus.valid = 1'b0;
        sh_x = 100;
        sh_y = -50;
        n_checks++; if (bus.active !== 1'b1) begin n_fail++; $display("FAIL activate: got %b required 1", bus.active); end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.out_valid) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL frame_on_rise_ignored: got %0d pulses required 0", pulses); end
        for (int i = 0; i < 2; i++) begin
            run_frame(fxs[i], sh_y, lat);
            model_frame(fxs[i], sh_y);
            n_checks++; if (lat != 4) begin n_fail++; $display("FAIL dz_latency[%0d]: got %0d edges required 4", i, lat); end
            n_checks++; if ($signed(bus.dx) !== exp_dx) begin n_fail++; $display("FAIL dz_dx[%0d]: got %0d required %0d", i, bus.dx, exp_dx); end
            n_checks++; if (int'(bus.cursor_x) !== exp_cx) begin n_fail++; $display("FAIL dz_cursor_x[%0d]: got %0d required %0d", i, bus.cursor_x, exp_cx); end
            tick();
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL dz_pulse_width[%0d]: got %b required 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_symmetry();
        int fxs[3] = '{20, 100, 100};
        int fys[3] = '{-50 + 33, -50 - 33, -50 + 17};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_frame(fxs[i], fys[i], lat);
            model_frame(fxs[i], fys[i]);
            n_checks++; if (lat != 4) begin n_fail++; $display("FAIL sym_latency[%0d]: got %0d required 4", i, lat); end
            n_checks++; if ($signed(bus.dx) !== exp_dx) begin n_fail++; $display("FAIL sym_dx[%0d]: got %0d required %0d", i, bus.dx, exp_dx); end
            n_checks++; if ($signed(bus.dy) !== exp_dy) begin n_fail++; $display("FAIL sym_dy[%0d]: got %0d required %0d", i, bus.dy, exp_dy); end
            n_checks++; if (int'(bus.cursor_x) !== exp_cx || int'(bus.cursor_y) !== exp_cy) begin
                n_fail++; $display("FAIL sym_cursor[%0d]: got (%0d,%0d) required (%0d,%0d)", i, bus.cursor_x, bus.cursor_y, exp_cx, exp_cy);
            end
        end
    endtask

    task automatic test_shadow();
        int lat;
        bus.offset_x = 16'sd3000;
        bus.offset_y = 16'sd2000;
        tick();
        run_frame(180, 33 - 50, lat);
        model_frame(180, 33 - 50);
        n_checks++; if ($signed(bus.dx) !== exp_dx) begin n_fail++; $display("FAIL shadow_dx: got %0d required %0d", bus.dx, exp_dx); end
        n_checks++; if ($signed(bus.dy) !== exp_dy) begin n_fail++; $display("FAIL shadow_dy: got %0d required %0d", bus.dy, exp_dy); end
    endtask

    task automatic test_random();
        int fx, fy, lat;
        for (int i = 0; i < 16; i++) begin
            fx = sh_x + int'($urandom_range(1200)) - 600;
            fy = sh_y + int'($urandom_range(1200)) - 600;
            run_frame(fx, fy, lat);
            model_frame(fx, fy);
            n_checks++; if (lat != 4) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d required 4", i, lat); end
            n_checks++; if ($signed(bus.dx) !== exp_dx || $signed(bus.dy) !== exp_dy) begin
                n_fail++; $display("FAIL rnd_step[%0d]: got (%0d,%0d) required (%0d,%0d)", i, bus.dx, bus.dy, exp_dx, exp_dy);
            end
            n_checks++; if (int'(bus.cursor_x) !== exp_cx || int'(bus.cursor_y) !== exp_cy) begin
                n_fail++; $display("FAIL rnd_cursor[%0d]: got (%0d,%0d) required (%0d,%0d)", i, bus.cursor_x, bus.cursor_y, exp_cx, exp_cy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit want;
        bus.recenter = 1'b1;
        tick();
        bus.recenter = 1'b0;
        exp_cx = SW / 2;
        exp_cy = SH / 2;
        n_checks++; if (bus.cursor_x !== 12'd960 || bus.cursor_y !== 12'd540) begin
            n_fail++; $display("FAIL recenter: got (%0d,%0d) required (960,540)", bus.cursor_x, bus.cursor_y);
        end
        bus.feat_x = 16'(sh_x + 32000);
        bus.feat_y = 16'(sh_y - 32000);
        bus.valid  = 1'b1;
        n = 0;
        for (int c = 0; c < 45; c++) begin
            tick();
            if (c == 34) bus.valid = 1'b0;
            want = (c >= 3 && c <= 37);
            n_checks++; if (bus.out_valid !== want) begin n_fail++; $display("FAIL b2b_out_valid[%0d]: got %b required %b", c, bus.out_valid, want); end
            if (bus.out_valid) begin
                n++;
                model_frame(sh_x + 32000, sh_y - 32000);
                n_checks++; if ($signed(bus.dx) !== 32 || $signed(bus.dy) !== -32) begin
                    n_fail++; $display("FAIL b2b_step[%0d]: got (%0d,%0d) required (32,-32)", n, bus.dx, bus.dy);
                end
                n_checks++; if (int'(bus.cursor_x) !== exp_cx || int'(bus.cursor_y) !== exp_cy) begin
                    n_fail++; $display("FAIL b2b_cursor[%0d]: got (%0d,%0d) required (%0d,%0d)", n, bus.cursor_x, bus.cursor_y, exp_cx, exp_cy);
                end
                if (n == 30) begin
                    n_checks++; if (bus.cursor_x !== 12'd1919) begin n_fail++; $display("FAIL b2b_wall: got %0d required 1919", bus.cursor_x); end
                end
            end
        end
        n_checks++; if (n != 35) begin n_fail++; $display("FAIL b2b_count: got %0d required 35", n); end
    endtask

    task automatic test_deactivate();
        int pulses, lat;
        bus.feat_x = 16'(sh_x + 500);
        bus.feat_y = 16'(sh_y + 500);
        bus.valid  = 1'b1;
        tick();
        tick();
        bus.valid      = 1'b0;
        bus.calibrated = 1'b0;
        tick();
        n_checks++; if (bus.active !== 1'b0) begin n_fail++; $display("FAIL deact_active: got %b required 0", bus.active); end
        pulses = bus.out_valid ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.out_valid) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL deact_dropped: got %0d pulses required 0", pulses); end
        n_checks++; if (int'(bus.cursor_x) !== exp_cx || int'(bus.cursor_y) !== exp_cy) begin
            n_fail++; $display("FAIL deact_cursor: got (%0d,%0d) required (%0d,%0d)", bus.cursor_x, bus.cursor_y, exp_cx, exp_cy);
        end
        n_checks++; if ($signed(bus.dx) !== exp_dx || $signed(bus.dy) !== exp_dy) begin
            n_fail++; $display("FAIL deact_step_hold: got (%0d,%0d) required (%0d,%0d)", bus.dx, bus.dy, exp_dx, exp_dy);
        end
        run_frame(sh_x + 500, sh_y, lat);
        n_checks++; if (lat != 8 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL inactive_frame: got out_valid after %0d edges required none", lat); end
    endtask

    task automatic test_recenter_collision();
        bus.offset_x   = 16'sd0;
        bus.offset_y   = 16'sd0;
        bus.calibrated = 1'b1;
        tick();
        sh_x = 0;
        sh_y = 0;
        n_checks++; if (bus.active !== 1'b1) begin n_fail++; $display("FAIL react_active: got %b required 1", bus.active); end
        bus.feat_x = 16'sd100;
        bus.feat_y = 16'sd0;
        bus.valid  = 1'b1;
        tick();
        bus.valid = 1'b0;
        tick();
        tick();
        bus.recenter = 1'b1;
        tick();
        bus.recenter = 1'b0;
        exp_dx = ref_step(100);
        exp_dy = 0;
        exp_cx = SW / 2;
        exp_cy = SH / 2;
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL collide_out_valid: got %b required 1", bus.out_valid); end
        n_checks++; if ($signed(bus.dx) !== exp_dx) begin n_fail++; $display("FAIL collide_dx: got %0d required %0d", bus.dx, exp_dx); end
        n_checks++; if (int'(bus.cursor_x) !== exp_cx || int'(bus.cursor_y) !== exp_cy) begin
            n_fail++; $display("FAIL collide_cursor: got (%0d,%0d) required (%0d,%0d)", bus.cursor_x, bus.cursor_y, exp_cx, exp_cy);
        end
    endtask

    task automatic test_reset_midflight();
        int lat, pulses;
        run_frame(200, 0, lat);
        model_frame(200, 0);
        n_checks++; if (int'(bus.cursor_x) !== exp_cx) begin n_fail++; $display("FAIL pre_reset_cursor_x: got %0d required %0d", bus.cursor_x, exp_cx); end
        bus.feat_x = 16'sd400;
        bus.valid  = 1'b1;
        tick();
        bus.valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (bus.active !== 1'b0) begin n_fail++; $display("FAIL midrst_active: got %b required 0", bus.active); end
        n_checks++; if (bus.cursor_x !== 12'd960 || bus.dx !== 8'sd0) begin
            n_fail++; $display("FAIL midrst_state: got cursor_x %0d dx %0d required 960 and 0", bus.cursor_x, bus.dx);
        end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.out_valid) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL midrst_dropped: got %0d pulses required 0", pulses); end
    endtask

    initial begin
        rst            = 1'b0;
        bus.valid      = 1'b0;
        bus.feat_x     = '0;
        bus.feat_y     = '0;
        bus.offset_x   = '0;
        bus.offset_y   = '0;
        bus.calibrated = 1'b0;
        bus.recenter   = 1'b0;
        test_reset();
        test_deadzone_gain();
        test_symmetry();
        test_shadow();
        test_random();
        test_back_to_back();
        test_deactivate();
        test_recenter_collision();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
